// File: rtl/local_field_accumulator.sv
// Local field accumulator: sums the lanes of each product vector, accumulates BEATS vectors with
// per-addition saturation, then holds the field, spin decision and flip flag under valid/ready.
module local_field_accumulator #(
    parameter int unsigned word_size  = 4,
    parameter int unsigned array_size = 51,
    parameter int unsigned BEATS      = 2,
    parameter int unsigned acc_width  = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [((array_size - 5) / 2)*word_size-1:0]   product_vector,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          spin_current,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [acc_width-1:0]                          field,
    output logic                                          spin_next,
    output logic                                          flip
);

    localparam int unsigned L  = (array_size - 5) / 2;
    localparam int unsigned SW = acc_width + $clog2(L);
    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] StAcc  = 1'b0;
    localparam logic [0:0] StDone = 1'b1;

    localparam logic signed [SW:0] SatMax = {{(SW - acc_width + 2){1'b0}}, {(acc_width - 1){1'b1}}};
    localparam logic signed [SW:0] SatMin = {{(SW - acc_width + 2){1'b1}}, {(acc_width - 1){1'b0}}};

    logic [0:0]                  state_q;
    logic [CW-1:0]               beat_cnt_q;
    logic signed [acc_width-1:0] acc_q;
    logic                        spin_q;

    logic signed [SW-1:0]        lane_sum;
    logic signed [acc_width-1:0] acc_base;
    logic signed [SW:0]          sum_wide;
    logic signed [acc_width-1:0] acc_sat;
    logic                        first_beat;
    logic                        last_beat;
    logic                        xfer;
    logic                        spin_eff;
    logic                        decision;

    assign in_ready   = (state_q == StAcc) && !rst;
    assign out_valid  = (state_q == StDone);
    assign xfer       = in_valid && in_ready;
    assign first_beat = (beat_cnt_q == '0);
    assign last_beat  = (beat_cnt_q == CW'(BEATS - 1));
    // The spin in effect is the one latched on beat 0, which is the live input during beat 0.
    assign spin_eff   = first_beat ? spin_current : spin_q;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < L; i++) begin
            lane_sum = lane_sum + SW'($signed(product_vector[word_size*i +: word_size]));
        end
    end

    always_comb begin
        acc_base = first_beat ? '0 : acc_q;
        sum_wide = (SW + 1)'(acc_base) + (SW + 1)'(lane_sum);
        if (sum_wide > SatMax) begin
            acc_sat = SatMax[acc_width-1:0];
        end else if (sum_wide < SatMin) begin
            acc_sat = SatMin[acc_width-1:0];
        end else begin
            acc_sat = acc_width'(sum_wide);
        end
    end

    always_comb begin
        if (acc_sat[acc_width-1]) begin
            decision = 1'b0;
        end else if (|acc_sat) begin
            decision = 1'b1;
        end else begin
            decision = spin_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StAcc;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            spin_q     <= 1'b0;
            field      <= '0;
            spin_next  <= 1'b0;
            flip       <= 1'b0;
        end else begin
            case (state_q)
                StAcc: begin
                    if (xfer) begin
                        acc_q <= acc_sat;
                        if (first_beat) begin
                            spin_q <= spin_current;
                        end
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            state_q    <= StDone;
                            field      <= acc_sat;
                            spin_next  <= decision;
                            flip       <= decision ^ spin_eff;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_q <= StAcc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_field_accumulator.sv
// Self-checking bench for local_field_accumulator: directed and random two-beat fields checked
// against an arithmetic model, on a 12-bit and an 8-bit accumulator instance fed the same beats.
module tb_local_field_accumulator;

    localparam int L  = 23;
    localparam int PW = L * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] product_vector = '0;
    logic          in_valid = 1'b0;
    logic          spin_current = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, spin_next, flip;
    logic [11:0]   field;
    logic          in_ready8, out_valid8, spin_next8, flip8;
    logic [7:0]    field8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    local_field_accumulator #(
        .word_size(4), .array_size(51), .BEATS(2), .acc_width(12)
    ) dut (
        .clk(clk), .rst(rst), .product_vector(product_vector), .in_valid(in_valid),
        .in_ready(in_ready), .spin_current(spin_current), .out_valid(out_valid),
        .out_ready(out_ready), .field(field), .spin_next(spin_next), .flip(flip)
    );

    local_field_accumulator #(
        .word_size(4), .array_size(51), .BEATS(2), .acc_width(8)
    ) dut8 (
        .clk(clk), .rst(rst), .product_vector(product_vector), .in_valid(in_valid),
        .in_ready(in_ready8), .spin_current(spin_current), .out_valid(out_valid8),
        .out_ready(out_ready), .field(field8), .spin_next(spin_next8), .flip(flip8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] fill(input logic [3:0] n);
        logic [PW-1:0] r;
        for (int i = 0; i < L; i++) r[4*i +: 4] = n;
        return r;
    endfunction

    function automatic logic [PW-1:0] rnd_vec();
        logic [PW-1:0] r;
        for (int i = 0; i < L; i++) r[4*i +: 4] = 4'($urandom);
        return r;
    endfunction

    // Field of a two-beat accumulation for accumulator width aw, clamped after each beat.
    function automatic int model_field(input logic [PW-1:0] v0, input logic [PW-1:0] v1,
                                       input int aw);
        int acc = 0;
        int s;
        int hi = (1 << (aw - 1)) - 1;
        int lo = -(1 << (aw - 1));
        logic [PW-1:0] v;
        for (int b = 0; b < 2; b++) begin
            v = (b == 0) ? v0 : v1;
            s = 0;
            for (int i = 0; i < L; i++) s += int'($signed(v[4*i +: 4]));
            acc = acc + s;
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        return acc;
    endfunction

    function automatic int model_spin(input int f, input logic spin);
        if (f > 0) return 1;
        if (f < 0) return 0;
        return int'(spin);
    endfunction

    task automatic check_result(input string tag, input logic [PW-1:0] v0,
                                input logic [PW-1:0] v1, input logic spin);
        int f12, f8, s12, s8;
        f12 = model_field(v0, v1, 12);
        f8  = model_field(v0, v1, 8);
        s12 = model_spin(f12, spin);
        s8  = model_spin(f8, spin);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_field"}, 32'($signed(field)), f12);
        chk({tag, "_spin"}, 32'(spin_next), s12);
        chk({tag, "_flip"}, 32'(flip), s12 ^ int'(spin));
        chk({tag, "_field8"}, 32'($signed(field8)), f8);
        chk({tag, "_spin8"}, 32'(spin_next8), s8);
        chk({tag, "_flip8"}, 32'(flip8), s8 ^ int'(spin));
    endtask

    // Two back-to-back beats with out_ready held high; spin_current flips on beat 1.
    task automatic run_field(input string tag, input logic [PW-1:0] v0,
                             input logic [PW-1:0] v1, input logic spin);
        out_ready = 1'b1;
        chk({tag, "_rdy0"}, 32'(in_ready), 1);
        product_vector = v0;
        spin_current   = spin;
        in_valid       = 1'b1;
        step();
        chk({tag, "_early"}, 32'(out_valid), 0);
        chk({tag, "_rdy1"}, 32'(in_ready), 1);
        product_vector = v1;
        spin_current   = ~spin;
        step();
        in_valid = 1'b0;
        check_result(tag, v0, v1, spin);
        step();
        chk({tag, "_drop"}, 32'(out_valid), 0);
        chk({tag, "_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [PW-1:0] va, vb, vc, vd, lane5, lanem5;
        int held;

        // Reset
        step();
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_field", 32'($signed(field)), 0);
        chk("rst_spin", 32'(spin_next), 0);
        chk("rst_flip", 32'(flip), 0);
        chk("rst_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 1);

        // Directed fields
        run_field("pos3", fill(4'h3), fill(4'h3), 1'b0);
        chk("pos3_138", 32'($signed(field)), 138);
        run_field("neg3", fill(4'hD), fill(4'hD), 1'b1);
        chk("neg3_m138", 32'($signed(field)), -138);
        lane5  = '0;
        lane5[3:0] = 4'h5;
        lanem5 = '0;
        lanem5[3:0] = 4'hB;
        run_field("zero_s0", lane5, lanem5, 1'b0);
        run_field("zero_s1", lane5, lanem5, 1'b1);
        run_field("sat_pos", fill(4'h7), fill(4'h7), 1'b0);
        chk("sat_pos_127", 32'($signed(field8)), 127);
        run_field("sat_neg", fill(4'h9), fill(4'h9), 1'b1);
        chk("sat_neg_m128", 32'($signed(field8)), -128);
        // Saturate negative on beat 0, then recover from the clamped value on beat 1
        run_field("sticky", fill(4'h8), fill(4'h7), 1'b1);

        // Random fields
        for (int n = 0; n < 24; n++) begin
            va = rnd_vec();
            vb = rnd_vec();
            run_field($sformatf("rnd%0d", n), va, vb, 1'($urandom));
        end

        // Back-pressure: result held, input ignored
        va = rnd_vec();
        vb = rnd_vec();
        vc = rnd_vec();
        vd = rnd_vec();
        out_ready      = 1'b0;
        in_valid       = 1'b1;
        product_vector = va;
        spin_current   = 1'b1;
        step();
        product_vector = vb;
        spin_current   = 1'b0;
        step();
        product_vector = vc;
        check_result("hold", va, vb, 1'b1);
        held = model_field(va, vb, 12);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold%0d_valid", c), 32'(out_valid), 1);
            chk($sformatf("hold%0d_ready", c), 32'(in_ready), 0);
            chk($sformatf("hold%0d_field", c), 32'($signed(field)), held);
        end
        out_ready = 1'b1;
        step();
        chk("release_valid", 32'(out_valid), 0);
        chk("release_ready", 32'(in_ready), 1);
        spin_current = 1'b0;
        step();
        product_vector = vd;
        spin_current   = 1'b1;
        step();
        in_valid = 1'b0;
        check_result("after_hold", vc, vd, 1'b0);
        step();

        // Reset mid-accumulation discards the partial beat
        product_vector = fill(4'h1);
        in_valid       = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 0);
        step();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_field", 32'($signed(field)), 0);
        chk("mid_rst_spin", 32'(spin_next), 0);
        chk("mid_rst_flip", 32'(flip), 0);
        rst = 1'b0;
        #1;
        run_field("post_rst", fill(4'h2), fill(4'h2), 1'b0);
        chk("post_rst_92", 32'($signed(field)), 92);

        // Reset while holding a result
        out_ready      = 1'b0;
        in_valid       = 1'b1;
        product_vector = fill(4'h3);
        step();
        step();
        in_valid = 1'b0;
        chk("done_rst_pre", 32'(out_valid), 1);
        rst = 1'b1;
        step();
        chk("done_rst_valid", 32'(out_valid), 0);
        chk("done_rst_field", 32'($signed(field)), 0);
        rst = 1'b0;
        #1;
        run_field("final", rnd_vec(), rnd_vec(), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
